// File: rtl/isa_defs.sv
// Shared ISA constants, slot-FSM encoding and small decode helpers for the
// fetch-side delay-slot candidate queue.
package isa_defs;

  localparam logic [5:0]  OPCODE_J   = 6'h02;
  localparam logic [5:0]  OPCODE_BEQ = 6'h04;
  localparam logic [5:0]  OPCODE_BNE = 6'h05;
  localparam logic [31:0] INST_NOP   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SLOT_MANUAL,
    ST_SLOT_AUTO,
    ST_SLOT_NOP
  } slot_state_e;

  typedef enum logic [1:0] {
    SLOT_KIND_MANUAL,
    SLOT_KIND_AUTO,
    SLOT_KIND_NOP
  } slot_kind_e;

  typedef struct packed {
    logic       is_ctrl;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       backward;
  } branch_info_t;

  function automatic branch_info_t decode_branch(input logic [31:0] instr);
    branch_info_t b;
    b = '0;
    if (instr[31:26] == OPCODE_BEQ || instr[31:26] == OPCODE_BNE) begin
      b.is_ctrl  = 1'b1;
      b.rs       = instr[25:21];
      b.rt       = instr[20:16];
      b.backward = instr[15];
    end else if (instr[31:26] == OPCODE_J) begin
      b.is_ctrl  = 1'b1;
    end
    return b;
  endfunction

  function automatic slot_state_e kind_to_state(input slot_kind_e k);
    case (k)
      SLOT_KIND_MANUAL: return ST_SLOT_MANUAL;
      SLOT_KIND_AUTO:   return ST_SLOT_AUTO;
      default:          return ST_SLOT_NOP;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/slot_window_buf.sv
// Ring buffer of fetched words with a peek window of head, head+1, head+2 and
// a per-entry kill bit that can be set on head+2.
module slot_window_buf
  import isa_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [31:0]                push_instr,
  input  logic [31:0]                push_pc,
  input  logic                       pop,
  input  logic                       kill2,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                head_instr,
  output logic [31:0]                head_pc,
  output logic                       head_kill,
  output logic [31:0]                nxt1_instr,
  output logic [31:0]                nxt1_pc,
  output logic [31:0]                nxt2_instr,
  output logic [31:0]                nxt2_pc,
  output logic                       nxt2_kill
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic [DEPTH-1:0] kill_q;
  logic [PTR_W-1:0] rd_ptr, wr_ptr, idx1, idx2;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush;
  assign idx1    = rd_ptr + PTR_W'(1);
  assign idx2    = rd_ptr + PTR_W'(2);

  // NOTE: the payload array has no reset; validity is carried by count, so
  // only pointers, count and kill bits need clearing.
  always_ff @(posedge clk) begin
    if (do_push) begin
      instr_mem[wr_ptr] <= push_instr;
      pc_mem[wr_ptr]    <= push_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      kill_q  <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      kill_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      // head+2 never aliases the write slot while it holds a valid entry
      if (do_push) kill_q[wr_ptr] <= 1'b0;
      if (kill2 && count_q > CNT_W'(2)) kill_q[idx2] <= 1'b1;
    end
  end

  assign count      = count_q;
  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];
  assign head_kill  = kill_q[rd_ptr];
  assign nxt1_instr = instr_mem[idx1];
  assign nxt1_pc    = pc_mem[idx1];
  assign nxt2_instr = instr_mem[idx2];
  assign nxt2_pc    = pc_mem[idx2];
  assign nxt2_kill  = kill_q[idx2];

endmodule

// File: rtl/slot_candidate_queue.sv
// Fetch queue feeding the delay-slot scheduler and sequencing branch + slot
// issue to decode. Define SLOT_STATS_EN to add saturating slot statistics.
module slot_candidate_queue
  import isa_defs::*;
#(
  parameter int DEPTH    = 4,
  parameter int WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_is_slot,
  output logic        sch_branch_valid,
  output logic [31:0] sch_branch_pc,
  output logic [4:0]  sch_branch_rs,
  output logic [4:0]  sch_branch_rt,
  output logic        sch_branch_is_backward,
  output logic        sch_cand0_valid,
  output logic [31:0] sch_cand0_instr,
  output logic [31:0] sch_cand0_pc,
  output logic        sch_cand1_valid,
  output logic [31:0] sch_cand1_instr,
  output logic [31:0] sch_cand1_pc,
  input  logic        sch_manual_ok,
  input  logic        sch_auto_use,
  input  logic        sch_force_nop,
  input  logic        sch_wait,
  input  logic        sch_kill_cand1,
  input  logic [31:0] sch_auto_instr,
  input  logic [31:0] sch_auto_pc
`ifdef SLOT_STATS_EN
  ,
  output logic [15:0] stat_manual,
  output logic [15:0] stat_auto,
  output logic [15:0] stat_nop,
  output logic [15:0] stat_timeout
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] count;
  logic [31:0]      head_instr, head_pc, nxt1_instr, nxt1_pc, nxt2_instr, nxt2_pc;
  logic             head_kill, nxt2_kill, head_valid;
  logic             push, pop, kill2, slot_load, br_load, timeout_hit;
  branch_info_t     head_br;
  slot_kind_e       kind;
  slot_state_e      state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [31:0]      slot_instr_q, slot_pc_q, branch_pc_q;

  assign in_ready = (count < CNT_W'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;

  slot_window_buf #(.DEPTH(DEPTH)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push),
    .push_instr (in_instr),
    .push_pc    (in_pc),
    .pop        (pop),
    .kill2      (kill2),
    .count      (count),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .head_kill  (head_kill),
    .nxt1_instr (nxt1_instr),
    .nxt1_pc    (nxt1_pc),
    .nxt2_instr (nxt2_instr),
    .nxt2_pc    (nxt2_pc),
    .nxt2_kill  (nxt2_kill)
  );

  assign head_valid = (count != '0);
  assign head_br    = decode_branch(head_instr);

  assign sch_branch_valid       = (state_q == ST_RUN) && head_valid && !head_kill && head_br.is_ctrl;
  assign sch_branch_pc          = head_pc;
  assign sch_branch_rs          = head_br.rs;
  assign sch_branch_rt          = head_br.rt;
  assign sch_branch_is_backward = head_br.backward;
  assign sch_cand0_valid        = (count >= CNT_W'(2));
  assign sch_cand0_instr        = nxt1_instr;
  assign sch_cand0_pc           = nxt1_pc;
  assign sch_cand1_valid        = (count >= CNT_W'(3)) && !nxt2_kill;
  assign sch_cand1_instr        = nxt2_instr;
  assign sch_cand1_pc           = nxt2_pc;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pop         = 1'b0;
    kill2       = 1'b0;
    slot_load   = 1'b0;
    br_load     = 1'b0;
    timeout_hit = 1'b0;
    kind        = SLOT_KIND_NOP;
    out_valid   = 1'b0;
    out_instr   = INST_NOP;
    out_pc      = '0;
    out_is_slot = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (head_valid && head_kill) begin
          pop = 1'b1;
        end else if (head_valid && !head_br.is_ctrl) begin
          out_valid = 1'b1;
          out_instr = head_instr;
          out_pc    = head_pc;
          pop       = out_ready;
        end else if (head_valid) begin
          timeout_hit = (wait_q == 8'(WAIT_MAX));
          if (sch_wait && !timeout_hit) begin
            wait_d = wait_q + 8'd1;
          end else begin
            out_valid = 1'b1;
            out_instr = head_instr;
            out_pc    = head_pc;
            if (out_ready) begin
              pop     = 1'b1;
              wait_d  = '0;
              br_load = 1'b1;
              // an expired wait overrides whatever verdict is present
              if (timeout_hit)        kind = SLOT_KIND_NOP;
              else if (sch_manual_ok) kind = SLOT_KIND_MANUAL;
              else if (sch_auto_use)  kind = SLOT_KIND_AUTO;
              else                    kind = SLOT_KIND_NOP;
              if (kind == SLOT_KIND_AUTO) begin
                slot_load = 1'b1;
                kill2     = sch_kill_cand1 || sch_auto_use;
              end
              state_d = kind_to_state(kind);
            end
          end
        end
      end
      ST_SLOT_MANUAL: begin
        out_valid   = head_valid;
        out_instr   = head_instr;
        out_pc      = head_pc;
        out_is_slot = 1'b1;
        if (out_ready && head_valid) begin
          pop     = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_SLOT_AUTO: begin
        out_valid   = 1'b1;
        out_instr   = slot_instr_q;
        out_pc      = slot_pc_q;
        out_is_slot = 1'b1;
        if (out_ready) state_d = ST_RUN;
      end
      default: begin
        out_valid   = 1'b1;
        out_instr   = INST_NOP;
        out_pc      = branch_pc_q + 32'd4;
        out_is_slot = 1'b1;
        if (out_ready) state_d = ST_RUN;
      end
    endcase
    if (flush) begin
      state_d   = ST_RUN;
      wait_d    = '0;
      pop       = 1'b0;
      kill2     = 1'b0;
      slot_load = 1'b0;
      br_load   = 1'b0;
      out_valid = 1'b0;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      wait_q       <= '0;
      slot_instr_q <= INST_NOP;
      slot_pc_q    <= '0;
      branch_pc_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (slot_load) begin
        slot_instr_q <= sch_auto_instr;
        slot_pc_q    <= sch_auto_pc;
      end
      if (br_load) branch_pc_q <= head_pc;
    end
  end

`ifdef SLOT_STATS_EN
  logic entering;
  assign entering = (state_q == ST_RUN) && (state_d != ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_manual  <= '0;
      stat_auto    <= '0;
      stat_nop     <= '0;
      stat_timeout <= '0;
    end else if (entering) begin
      if (state_d == ST_SLOT_MANUAL) stat_manual <= sat_inc16(stat_manual);
      if (state_d == ST_SLOT_AUTO)   stat_auto   <= sat_inc16(stat_auto);
      if (state_d == ST_SLOT_NOP)    stat_nop    <= sat_inc16(stat_nop);
      if (timeout_hit)               stat_timeout <= sat_inc16(stat_timeout);
    end
  end
`endif

endmodule

// File: tb/tb_slot_candidate_queue.sv
// Directed self-checking bench for slot_candidate_queue (default build).
module tb_slot_candidate_queue;
  import isa_defs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc;
  logic        out_is_slot;
  logic        sch_branch_valid;
  logic [31:0] sch_branch_pc;
  logic [4:0]  sch_branch_rs, sch_branch_rt;
  logic        sch_branch_is_backward;
  logic        sch_cand0_valid, sch_cand1_valid;
  logic [31:0] sch_cand0_instr, sch_cand0_pc, sch_cand1_instr, sch_cand1_pc;
  logic        sch_manual_ok = 1'b0, sch_auto_use = 1'b0, sch_force_nop = 1'b0;
  logic        sch_wait = 1'b0, sch_kill_cand1 = 1'b0;
  logic [31:0] sch_auto_instr = '0, sch_auto_pc = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  slot_candidate_queue #(.DEPTH(4), .WAIT_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_is_slot(out_is_slot),
    .sch_branch_valid(sch_branch_valid), .sch_branch_pc(sch_branch_pc),
    .sch_branch_rs(sch_branch_rs), .sch_branch_rt(sch_branch_rt),
    .sch_branch_is_backward(sch_branch_is_backward),
    .sch_cand0_valid(sch_cand0_valid), .sch_cand0_instr(sch_cand0_instr),
    .sch_cand0_pc(sch_cand0_pc),
    .sch_cand1_valid(sch_cand1_valid), .sch_cand1_instr(sch_cand1_instr),
    .sch_cand1_pc(sch_cand1_pc),
    .sch_manual_ok(sch_manual_ok), .sch_auto_use(sch_auto_use),
    .sch_force_nop(sch_force_nop), .sch_wait(sch_wait),
    .sch_kill_cand1(sch_kill_cand1),
    .sch_auto_instr(sch_auto_instr), .sch_auto_pc(sch_auto_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; checks follow 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return {6'h08, rs, rt, imm};
  endfunction
  function automatic logic [31:0] add_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction
  function automatic logic [31:0] beq(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] off);
    return {6'h04, rs, rt, off};
  endfunction
  function automatic logic [31:0] bne(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] off);
    return {6'h05, rs, rt, off};
  endfunction

  initial begin
    logic [31:0] add_w;
    add_w = add_r(5'd5, 5'd1, 5'd2);

    // reset values
    rst_n = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_is_slot", 32'(out_is_slot), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sch_valids", {29'd0, sch_branch_valid, sch_cand0_valid, sch_cand1_valid}, 32'd0);
    rst_n = 1'b1;
    tick();

    // straight-line
    push(addi(5'd1, 5'd0, 16'd1), 32'h00);
    push(addi(5'd2, 5'd0, 16'd2), 32'h04);
    push(addi(5'd3, 5'd0, 16'd3), 32'h08);
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("line_valid", 32'(out_valid), 32'd1);
      check("line_pc", out_pc, 32'(i * 4));
      check("line_slot", 32'(out_is_slot), 32'd0);
      tick();
    end
    check("line_empty", 32'(out_valid), 32'd0);

    // manual slot
    out_ready = 1'b0;
    push(beq(5'd1, 5'd2, 16'd4), 32'h10);
    push(addi(5'd3, 5'd3, 16'd1), 32'h14);
    push(add_r(5'd4, 5'd1, 5'd2), 32'h18);
    check("man_br_valid", 32'(sch_branch_valid), 32'd1);
    check("man_br_rs_rt", {22'd0, sch_branch_rs, sch_branch_rt}, {22'd0, 5'd1, 5'd2});
    check("man_br_back", 32'(sch_branch_is_backward), 32'd0);
    check("man_cand0_pc", sch_cand0_pc, 32'h14);
    check("man_cand1", {31'd0, sch_cand1_valid}, 32'd1);
    check("man_cand1_pc", sch_cand1_pc, 32'h18);
    sch_manual_ok = 1'b1;
    out_ready = 1'b1;
    #1;
    check("man_br_pc", out_pc, 32'h10);
    check("man_br_slot", 32'(out_is_slot), 32'd0);
    tick();
    sch_manual_ok = 1'b0;
    #1;
    check("man_slot_pc", out_pc, 32'h14);
    check("man_slot_flag", 32'(out_is_slot), 32'd1);
    check("man_slot_brv", 32'(sch_branch_valid), 32'd0);
    tick();
    check("man_after_pc", out_pc, 32'h18);
    check("man_after_slot", 32'(out_is_slot), 32'd0);
    tick();
    check("man_empty", 32'(out_valid), 32'd0);

    // auto (hoisted) slot
    out_ready = 1'b0;
    push(bne(5'd3, 5'd0, 16'hFFFE), 32'h20);
    push(addi(5'd3, 5'd3, 16'd1), 32'h24);
    push(add_w, 32'h28);
    check("auto_br_back", 32'(sch_branch_is_backward), 32'd1);
    check("auto_br_rs_rt", {22'd0, sch_branch_rs, sch_branch_rt}, {22'd0, 5'd3, 5'd0});
    sch_auto_use   = 1'b1;
    sch_kill_cand1 = 1'b1;
    sch_auto_instr = add_w;
    sch_auto_pc    = 32'h28;
    out_ready      = 1'b1;
    #1;
    check("auto_br_pc", out_pc, 32'h20);
    tick();
    sch_auto_use   = 1'b0;
    sch_kill_cand1 = 1'b0;
    sch_auto_instr = 32'hDEAD_BEEF;
    sch_auto_pc    = 32'hBAD0;
    #1;
    check("auto_slot_pc", out_pc, 32'h28);
    check("auto_slot_instr", out_instr, add_w);
    check("auto_slot_flag", 32'(out_is_slot), 32'd1);
    tick();
    check("auto_cand0_pc", out_pc, 32'h24);
    check("auto_cand0_slot", 32'(out_is_slot), 32'd0);
    tick();
    check("auto_killed_drop", 32'(out_valid), 32'd0);
    tick();
    check("auto_empty", 32'(out_valid), 32'd0);
    check("auto_empty_c0", 32'(sch_cand0_valid), 32'd0);

    // timeout
    sch_wait = 1'b1;
    push(beq(5'd6, 5'd7, 16'd8), 32'h40);
    for (int i = 0; i < 8; i++) begin
      check("to_wait", 32'(out_valid), 32'd0);
      tick();
    end
    check("to_br_valid", 32'(out_valid), 32'd1);
    check("to_br_pc", out_pc, 32'h40);
    tick();
    check("to_nop_instr", out_instr, INST_NOP);
    check("to_nop_pc", out_pc, 32'h44);
    check("to_nop_slot", 32'(out_is_slot), 32'd1);
    tick();
    check("to_empty", 32'(out_valid), 32'd0);
    sch_wait = 1'b0;

    // flush while in SLOT_AUTO
    out_ready = 1'b0;
    push(bne(5'd1, 5'd0, 16'd3), 32'h50);
    push(addi(5'd1, 5'd1, 16'd1), 32'h54);
    push(add_w, 32'h58);
    push(addi(5'd2, 5'd2, 16'd1), 32'h5C);
    check("fl_full_ready", 32'(in_ready), 32'd0);
    sch_auto_use = 1'b1;
    sch_auto_pc  = 32'h58;
    out_ready    = 1'b1;
    tick();
    sch_auto_use = 1'b0;
    check("fl_in_auto", 32'(out_is_slot), 32'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = addi(5'd9, 5'd9, 16'd9);
    in_pc    = 32'h99;
    #1;
    check("fl_valid_now", 32'(out_valid), 32'd0);
    check("fl_ready_now", 32'(in_ready), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    check("fl_c0_valid", 32'(sch_cand0_valid), 32'd0);
    push(addi(5'd1, 5'd0, 16'd7), 32'h60);
    check("fl_run_pc", out_pc, 32'h60);
    check("fl_run_slot", 32'(out_is_slot), 32'd0);
    tick();

    // backpressure then asynchronous reset
    out_ready = 1'b0;
    push(addi(5'd1, 5'd0, 16'd1), 32'h70);
    push(addi(5'd2, 5'd0, 16'd2), 32'h74);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_pc", out_pc, 32'h70);
      check("bp_instr", out_instr, addi(5'd1, 5'd0, 16'd1));
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_pc", out_pc, 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_c0", 32'(sch_cand0_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
